// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults, derived sync positions and shared helpers
package vga_timing_pkg;
  typedef logic [9:0] coord_t;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  localparam int PIX_LAT_DEF = 1;
  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END = HS_START + H_SYNC_DEF - 1;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END = VS_START + V_SYNC_DEF - 1;
  function automatic logic in_rng(coord_t v, coord_t lo, coord_t hi);
    return v >= lo && v <= hi;
  endfunction
endpackage

// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if: pixel request/return path and VGA DAC pins
interface vga_timing_ctrl_if;
  logic [9:0] oXPOS, oYPOS;
  logic       oREQ;
  logic [9:0] iRED, iGREEN, iBLUE;
  logic [9:0] oVGA_R, oVGA_G, oVGA_B;
  logic       oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, oFRAME_TICK;
  modport master (
    output oXPOS, oYPOS, oREQ, oVGA_R, oVGA_G, oVGA_B,
    output oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, oFRAME_TICK,
    input  iRED, iGREEN, iBLUE
  );
  modport slave (
    input  oXPOS, oYPOS, oREQ, oVGA_R, oVGA_G, oVGA_B,
    input  oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, oFRAME_TICK,
    output iRED, iGREEN, iBLUE
  );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage register pipeline with synchronous active-low reset to RESET_VAL
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];
  always_comb begin
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) pipe_q[i] <= RESET_VAL;
    else pipe_q <= pipe_d;
  assign q = pipe_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: raster counters, pixel request regs and DAC output stage
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter int PIX_LAT = PIX_LAT_DEF
) (
  input logic iCLK,
  input logic iRST_N,
  vga_timing_ctrl_if.master vga
);
  localparam coord_t HA = coord_t'(H_ACTIVE);
  localparam coord_t HS0 = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS1 = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t HL = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t VA = coord_t'(V_ACTIVE);
  localparam coord_t VS0 = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS1 = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam coord_t VL = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  coord_t h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, xpos_q, xpos_d, ypos_q, ypos_d;
  coord_t r_q, r_d, g_q, g_d, b_q, b_d;
  logic   req_q, req_d, hs_q, hs_d, vs_q, vs_d, tick_q, tick_d;
  logic   blank_q, blank_d, ohs_q, ohs_d, ovs_q, ovs_d, act;
  logic [2:0] dly;
  always_comb begin
    h_cnt_d = h_cnt_q == HL ? '0 : h_cnt_q + 10'd1;
    v_cnt_d = h_cnt_q != HL ? v_cnt_q : v_cnt_q == VL ? '0 : v_cnt_q + 10'd1;
    act     = h_cnt_q < HA && v_cnt_q < VA;
    req_d   = act;
    xpos_d  = act ? h_cnt_q : '0;
    ypos_d  = act ? v_cnt_q : '0;
    hs_d    = !in_rng(h_cnt_q, HS0, HS1);
    vs_d    = !in_rng(v_cnt_q, VS0, VS1);
    tick_d  = h_cnt_q == '0 && v_cnt_q == VA;
    blank_d = dly[2];
    ohs_d   = dly[1];
    ovs_d   = dly[0];
    r_d     = dly[2] ? vga.iRED : '0;
    g_d     = dly[2] ? vga.iGREEN : '0;
    b_d     = dly[2] ? vga.iBLUE : '0;
  end
  always_ff @(posedge iCLK)
    if (!iRST_N) begin
      {h_cnt_q, v_cnt_q, xpos_q, ypos_q, r_q, g_q, b_q} <= '0;
      {req_q, tick_q, blank_q} <= '0;
      {hs_q, vs_q, ohs_q, ovs_q} <= '1;
    end else begin
      {h_cnt_q, v_cnt_q, xpos_q, ypos_q, r_q, g_q, b_q} <= {h_cnt_d, v_cnt_d, xpos_d, ypos_d, r_d, g_d, b_d};
      {req_q, tick_q, blank_q} <= {req_d, tick_d, blank_d};
      {hs_q, vs_q, ohs_q, ovs_q} <= {hs_d, vs_d, ohs_d, ovs_d};
    end
  // {act, hs, vs} follow the colour generator's latency so syncs frame the returned pixel
  vga_delay_line #(.WIDTH(3), .DEPTH(PIX_LAT), .RESET_VAL(3'b011)) u_dly (
    .clk(iCLK), .rst_n(iRST_N), .d({req_q, hs_q, vs_q}), .q(dly)
  );
  assign vga.oXPOS = xpos_q;
  assign vga.oYPOS = ypos_q;
  assign vga.oREQ = req_q;
  assign vga.oFRAME_TICK = tick_q;
  assign vga.oVGA_R = r_q;
  assign vga.oVGA_G = g_q;
  assign vga.oVGA_B = b_q;
  assign vga.oVGA_BLANK_N = blank_q;
  assign vga.oVGA_HS = ohs_q;
  assign vga.oVGA_VS = ovs_q;
  assign vga.oVGA_SYNC_N = 1'b0;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: full-size 640x480 instance (PIX_LAT=1) and a shrunken raster (PIX_LAT=3)
module tb_vga_timing_ctrl;
  typedef struct packed {int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lat;} geo_t;
  localparam geo_t G0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
  localparam geo_t G1 = '{16, 2, 3, 4, 8, 1, 2, 2, 3};
  logic iCLK = 0, iRST_N = 0;
  int n_pass = 0, n_fail = 0, c;
  logic [32:0] pq0[$], pq1[$];
  logic [21:0] rq0[$], rq1[$];
  logic p_hs0, p_bl0, p_vs1;
  int hs_fall, bl_rise, vs_fall, tk_last;
  bit bl_seen;
  always #5 iCLK = ~iCLK;
  vga_timing_ctrl_if if0 ();
  vga_timing_ctrl_if if1 ();
  vga_timing_ctrl #(.PIX_LAT(1)) dut0 (.iCLK(iCLK), .iRST_N(iRST_N), .vga(if0.master));
  vga_timing_ctrl #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(8), .V_FP(1),
    .V_SYNC(2), .V_BP(2), .PIX_LAT(3)) dut1 (.iCLK(iCLK), .iRST_N(iRST_N), .vga(if1.master));
  logic [9:0] x0_q, y0_q, x1_q[3], y1_q[3];
  always_ff @(posedge iCLK) begin
    x0_q <= if0.oXPOS;
    y0_q <= if0.oYPOS;
    x1_q <= '{if1.oXPOS, x1_q[0], x1_q[1]};
    y1_q <= '{if1.oYPOS, y1_q[0], y1_q[1]};
  end
  assign if0.iRED = x0_q;
  assign if0.iGREEN = y0_q;
  assign if0.iBLUE = 10'h3FF;
  assign if1.iRED = x1_q[2];
  assign if1.iGREEN = y1_q[2];
  assign if1.iBLUE = 10'h3FF;
  function automatic logic [32:0] pin_exp(geo_t g, int t);
    int ht, vt, h, v;
    logic a;
    if (t < 0) return {3'b011, 30'd0};
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    h = t % ht;
    v = (t / ht) % vt;
    a = h < g.ha && v < g.va;
    return {a, !(h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hsw),
            !(v >= g.va + g.vfp && v < g.va + g.vfp + g.vsw),
            a ? 10'(h) : 10'd0, a ? 10'(v) : 10'd0, a ? 10'h3FF : 10'd0};
  endfunction
  function automatic logic [21:0] req_exp(geo_t g, int t);
    int ht, vt, h, v;
    logic a;
    if (t < 0) return '0;
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    h = t % ht;
    v = (t / ht) % vt;
    a = h < g.ha && v < g.va;
    return {a, a ? 10'(h) : 10'd0, a ? 10'(v) : 10'd0, h == 0 && v == g.va};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge iCLK);
    #1;
  endtask
  task automatic rst_chk();
    chk("rst_req0", {if0.oREQ, if0.oXPOS, if0.oYPOS, if0.oFRAME_TICK}, 0);
    chk("rst_pin0", {if0.oVGA_BLANK_N, if0.oVGA_HS, if0.oVGA_VS, if0.oVGA_R, if0.oVGA_G, if0.oVGA_B}, {3'b011, 30'd0});
    chk("rst_sync0", if0.oVGA_SYNC_N, 0);
    chk("rst_req1", {if1.oREQ, if1.oXPOS, if1.oYPOS, if1.oFRAME_TICK}, 0);
    chk("rst_pin1", {if1.oVGA_BLANK_N, if1.oVGA_HS, if1.oVGA_VS, if1.oVGA_R, if1.oVGA_G, if1.oVGA_B}, {3'b011, 30'd0});
    chk("rst_sync1", if1.oVGA_SYNC_N, 0);
  endtask
  task automatic restart();
    c = 0;
    pq0.delete(); pq1.delete(); rq0.delete(); rq1.delete();
    for (int i = 0; i < G0.lat + 2; i++) pq0.push_back(pin_exp(G0, -1));
    for (int i = 0; i < G1.lat + 2; i++) pq1.push_back(pin_exp(G1, -1));
    rq0.push_back(req_exp(G0, -1));
    rq1.push_back(req_exp(G1, -1));
    {p_hs0, p_bl0, p_vs1} = 3'b101;
    {hs_fall, bl_rise, vs_fall, tk_last} = {-32'sd1, -32'sd1, -32'sd1, -32'sd1};
    bl_seen = 0;
  endtask
  task automatic cycle_checks();
    rq0.push_back(req_exp(G0, c));
    chk("req0", {if0.oREQ, if0.oXPOS, if0.oYPOS, if0.oFRAME_TICK}, rq0.pop_front());
    pq0.push_back(pin_exp(G0, c));
    chk("pin0", {if0.oVGA_BLANK_N, if0.oVGA_HS, if0.oVGA_VS, if0.oVGA_R, if0.oVGA_G, if0.oVGA_B}, pq0.pop_front());
    rq1.push_back(req_exp(G1, c));
    chk("req1", {if1.oREQ, if1.oXPOS, if1.oYPOS, if1.oFRAME_TICK}, rq1.pop_front());
    pq1.push_back(pin_exp(G1, c));
    chk("pin1", {if1.oVGA_BLANK_N, if1.oVGA_HS, if1.oVGA_VS, if1.oVGA_R, if1.oVGA_G, if1.oVGA_B}, pq1.pop_front());
    if (p_hs0 && !if0.oVGA_HS) begin
      if (hs_fall < 0) chk("hs_first_fall", c, 659);
      else chk("hs_period", c - hs_fall, 800);
      hs_fall = c;
    end
    if (!p_hs0 && if0.oVGA_HS && hs_fall >= 0) chk("hs_width", c - hs_fall, 96);
    if (!p_bl0 && if0.oVGA_BLANK_N) begin
      if (!bl_seen) chk("blank_first_rise", c, 3);
      bl_seen = 1;
      bl_rise = c;
    end
    if (p_bl0 && !if0.oVGA_BLANK_N && bl_rise >= 0) chk("blank_run", c - bl_rise, 640);
    if (p_vs1 && !if1.oVGA_VS) begin
      if (vs_fall < 0) chk("vs_first_fall", c, 9 * 25 + 5);
      else chk("vs_period", c - vs_fall, 325);
      vs_fall = c;
    end
    if (!p_vs1 && if1.oVGA_VS && vs_fall >= 0) chk("vs_width", c - vs_fall, 50);
    if (if1.oFRAME_TICK) begin
      if (tk_last < 0) chk("tick_first", c, 8 * 25 + 1);
      else chk("tick_period", c - tk_last, 325);
      tk_last = c;
    end
    {p_hs0, p_bl0, p_vs1} = {if0.oVGA_HS, if0.oVGA_BLANK_N, if1.oVGA_VS};
  endtask
  initial begin
    repeat (5) step();
    rst_chk();
    iRST_N = 1;
    restart();
    cycle_checks();
    for (int i = 0; i < 1900; i++) begin
      step();
      c++;
      cycle_checks();
    end
    // full-size raster now at line 2, column 300: pulse reset for one cycle
    iRST_N = 0;
    step();
    rst_chk();
    iRST_N = 1;
    restart();
    cycle_checks();
    for (int i = 0; i < 1000; i++) begin
      step();
      c++;
      cycle_checks();
    end
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
